// File: rtl/writeback_arbiter_pkg.sv
// Shared register-file constants and writeback arbiter types.
// Used by writeback_arbiter, its interface and the optional forwarding comparator.
package writeback_arbiter_pkg;

  localparam int REG_ADDR  = 5;
  localparam int REG_WIDTH = 32;
  localparam int REG_NUM   = 32;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W_DEF        = 3;

  typedef enum logic {
    MEM_PRIO  = 1'b0,
    ALU_FORCE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_ADDR-1:0]  rd;
    logic [REG_WIDTH-1:0] data;
  } wb_req_t;

  // x0 is hardwired to zero, so writes to it are accepted but never enabled.
  function automatic logic is_x0(input logic [REG_ADDR-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer/register-file bundle for writeback_arbiter; forwarding signals
// exist only when WB_FORWARD_EN is defined.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  // Handshake: a result moves when i_*_valid && o_*_ready in the same cycle.
  // Ready is combinational from both valids and the arbiter state, never from
  // the source's own ready; a source holds rd/data stable until it sees ready.
  logic                 i_alu_valid;
  logic                 o_alu_ready;
  logic [REG_ADDR-1:0]  i_alu_rd;
  logic [REG_WIDTH-1:0] i_alu_data;

  logic                 i_mem_valid;
  logic                 o_mem_ready;
  logic [REG_ADDR-1:0]  i_mem_rd;
  logic [REG_WIDTH-1:0] i_mem_data;

  logic                 o_write_enable;
  logic [REG_ADDR-1:0]  o_write_select;
  logic [REG_WIDTH-1:0] o_write_data;
  logic                 o_starved;

`ifdef WB_FORWARD_EN
  logic [REG_ADDR-1:0]  i_read_select_a;
  logic [REG_ADDR-1:0]  i_read_select_b;
  logic                 o_fwd_hit_a;
  logic                 o_fwd_hit_b;
  logic [REG_WIDTH-1:0] o_fwd_data_a;
  logic [REG_WIDTH-1:0] o_fwd_data_b;
`endif

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_mem_valid, i_mem_rd, i_mem_data,
    output o_alu_ready, o_mem_ready,
    output o_write_enable, o_write_select, o_write_data, o_starved
`ifdef WB_FORWARD_EN
    , input  i_read_select_a, i_read_select_b
    , output o_fwd_hit_a, o_fwd_hit_b, o_fwd_data_a, o_fwd_data_b
`endif
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_mem_valid, i_mem_rd, i_mem_data,
    input  o_alu_ready, o_mem_ready,
    input  o_write_enable, o_write_select, o_write_data, o_starved
`ifdef WB_FORWARD_EN
    , output i_read_select_a, i_read_select_b
    , input  o_fwd_hit_a, o_fwd_hit_b, o_fwd_data_a, o_fwd_data_b
`endif
  );

endinterface

// File: rtl/writeback_arbiter_fwd_cmp.sv
// wb_fwd_cmp: one read-port comparator against the registered write port.
// Purely combinational; x0 never hits.
module wb_fwd_cmp
  import writeback_arbiter_pkg::*;
(
  input  logic                 write_enable,
  input  logic [REG_ADDR-1:0]  write_select,
  input  logic [REG_WIDTH-1:0] write_data,
  input  logic [REG_ADDR-1:0]  read_select,
  output logic                 hit,
  output logic [REG_WIDTH-1:0] fwd_data
);

  assign hit      = write_enable && (write_select == read_select) && !is_x0(read_select);
  assign fwd_data = hit ? write_data : '0;

endmodule

// File: rtl/writeback_arbiter.sv
// Two-source (ALU, MEM) arbiter for the single register-file write port with
// MEM priority, bounded ALU starvation and x0 suppression. WB_FORWARD_EN adds forwarding.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_arbiter_if.slave bus,
  output wb_state_e         dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_req_t alu_req;
  wb_req_t mem_req;

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                 alu_grant;
  logic                 mem_grant;
  logic [REG_ADDR-1:0]  win_rd;
  logic [REG_WIDTH-1:0] win_data;

  logic                 we_q;
  logic [REG_ADDR-1:0]  sel_q;
  logic [REG_WIDTH-1:0] data_q;

  assign alu_req = '{valid: bus.i_alu_valid, rd: bus.i_alu_rd, data: bus.i_alu_data};
  assign mem_req = '{valid: bus.i_mem_valid, rd: bus.i_mem_rd, data: bus.i_mem_data};

  // Grant selection, starvation counting and next state.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_rd    = mem_req.rd;
    win_data  = mem_req.data;

    case (state_q)
      MEM_PRIO: begin
        mem_grant = mem_req.valid;
        alu_grant = alu_req.valid && !mem_req.valid;
      end
      ALU_FORCE: begin
        alu_grant = alu_req.valid;
        mem_grant = mem_req.valid && !alu_req.valid;
      end
      default: begin
        mem_grant = mem_req.valid;
        alu_grant = alu_req.valid && !mem_req.valid;
      end
    endcase

    if (alu_grant) begin
      win_rd   = alu_req.rd;
      win_data = alu_req.data;
    end

    // The counter saturates at the limit; in ALU_FORCE a valid ALU is always granted.
    if (alu_grant) begin
      cnt_d = '0;
    end else if (alu_req.valid && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      MEM_PRIO:  if (cnt_d == LIMIT_C) state_d = ALU_FORCE;
      ALU_FORCE: if (alu_grant)        state_d = MEM_PRIO;
      default:   state_d = MEM_PRIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_PRIO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered write port: select/data only move on a grant, even one to x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      we_q <= (alu_grant || mem_grant) && !is_x0(win_rd);
      if (alu_grant || mem_grant) begin
        sel_q  <= win_rd;
        data_q <= win_data;
      end
    end
  end

  assign bus.o_alu_ready    = alu_grant;
  assign bus.o_mem_ready    = mem_grant;
  assign bus.o_write_enable = we_q;
  assign bus.o_write_select = sel_q;
  assign bus.o_write_data   = data_q;
  assign bus.o_starved      = (state_q == ALU_FORCE);

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = cnt_q;

`ifdef WB_FORWARD_EN
  logic                 hit_a, hit_b;
  logic [REG_WIDTH-1:0] fwd_a, fwd_b;

  wb_fwd_cmp u_fwd_cmp_a (
    .write_enable (we_q),
    .write_select (sel_q),
    .write_data   (data_q),
    .read_select  (bus.i_read_select_a),
    .hit          (hit_a),
    .fwd_data     (fwd_a)
  );

  wb_fwd_cmp u_fwd_cmp_b (
    .write_enable (we_q),
    .write_select (sel_q),
    .write_data   (data_q),
    .read_select  (bus.i_read_select_b),
    .hit          (hit_b),
    .fwd_data     (fwd_b)
  );

  assign bus.o_fwd_hit_a  = hit_a;
  assign bus.o_fwd_hit_b  = hit_b;
  assign bus.o_fwd_data_a = fwd_a;
  assign bus.o_fwd_data_b = fwd_b;
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_grant && mem_grant));
  a_grant_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (!alu_grant || alu_req.valid) && (!mem_grant || mem_req.valid));

endmodule
